// File: rtl/ahb_sram_responder_pkg.sv
// Shared types and encodings for the AHB SRAM responder: FSM states, AHB
// transfer/size encodings, response codes and byte-lane decode helpers.
package ahb_sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] offs);
    case (size)
      HSIZE_BYTE: return 4'b0001 << offs;
      HSIZE_HALF: return offs[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  // Sizes above a word are never aligned, which makes them illegal too.
  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] offs);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return ~offs[0];
      HSIZE_WORD: return offs == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_responder_mem.sv
// Word-addressed SRAM with four byte enables, synchronous write and
// combinational read. Contents are intentionally not reset.
module ahb_sram_responder_mem #(
  parameter int WORDS = 2048,
  parameter int AW    = 11
) (
  input  logic          clock,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM slave with fixed wait states, two-cycle ERROR responses and a
// saturating error counter. Define AHB_SRAM_RESPONDER_LFSR_WAIT_EN for LFSR waits.
module ahb_sram_responder
  import ahb_sram_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 30,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          MEM_BYTES   = 8192,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hready,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic [15:0]           err_count
);

  localparam int MEM_WORDS = MEM_BYTES / 4;
  localparam int WORD_AW   = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SIZE_A = ADDR_WIDTH'(MEM_BYTES);

  state_t               state, state_nx;
  logic [2:0]           wait_cnt, wait_cnt_nx;
  logic                 d_valid, d_valid_nx;
  logic                 d_write, d_write_nx;
  logic [WORD_AW-1:0]   d_word, d_word_nx;
  logic [3:0]           d_be, d_be_nx;
  logic [15:0]          err_count_nx;
  logic [ADDR_WIDTH-1:0] offset;
  logic                 accept, legal, take;
  logic [2:0]           wait_load;
  logic [31:0]          mem_rdata;
  logic                 mem_we;

  always_comb begin
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: accept = hready;
      HTRANS_IDLE, HTRANS_BUSY:  accept = 1'b0;
      default:                   accept = 1'b0;
    endcase
  end

  assign offset = haddr - BASE_A;
  assign legal  = (haddr >= BASE_A) && (offset < SIZE_A) && is_aligned(hsize, haddr[1:0]);
  // Only IDLE (incl. the last OKAY cycle) and ERR2 may start a new transfer.
  assign take   = accept && ((state == ST_IDLE) || (state == ST_ERR2));

`ifdef AHB_SRAM_RESPONDER_LFSR_WAIT_EN
  logic [2:0] lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    lfsr <= 3'b001;
    else if (take) lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
  end

  assign wait_load = lfsr;
`else
  assign wait_load = 3'(WAIT_CYCLES);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 3'd0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_word    <= '0;
      d_be      <= 4'b0000;
      err_count <= 16'd0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      d_valid   <= d_valid_nx;
      d_write   <= d_write_nx;
      d_word    <= d_word_nx;
      d_be      <= d_be_nx;
      err_count <= err_count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    d_valid_nx   = d_valid;
    d_write_nx   = d_write;
    d_word_nx    = d_word;
    d_be_nx      = d_be;
    err_count_nx = err_count;
    hreadyout    = 1'b1;
    hresp        = RESP_OKAY;
    case (state)
      ST_IDLE, ST_ERR2: begin
        hresp      = (state == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
        state_nx   = ST_IDLE;
        d_valid_nx = 1'b0;
        if (take) begin
          if (legal) begin
            d_valid_nx = 1'b1;
            d_write_nx = hwrite;
            d_word_nx  = offset[WORD_AW+1:2];
            d_be_nx    = byte_lanes(hsize, haddr[1:0]);
            if (wait_load != 3'd0) begin
              state_nx    = ST_WAIT;
              wait_cnt_nx = wait_load;
            end
          end else begin
            state_nx = ST_ERR1;
            if (err_count != 16'hFFFF) err_count_nx = err_count + 16'd1;
          end
        end
      end
      ST_WAIT: begin
        hreadyout   = 1'b0;
        wait_cnt_nx = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) state_nx = ST_IDLE;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
        state_nx  = ST_ERR2;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A pending transfer seen in IDLE is in its final, ready data-phase cycle.
  assign mem_we = d_valid && d_write && (state == ST_IDLE);
  assign hrdata = (d_valid && !d_write && (state == ST_IDLE)) ? mem_rdata : '0;

  ahb_sram_responder_mem #(
    .WORDS (MEM_WORDS),
    .AW    (WORD_AW)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .be    (d_be),
    .addr  (d_word),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench for ahb_sram_responder: one instance with zero wait states and
// one with three, sharing a master model that only talks to the selected one.
module tb_ahb_sram_responder;
  import ahb_sram_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [29:0] haddr;
  logic [31:0] hwdata;
  logic        sel;

  logic [1:0]  htrans_0, htrans_3;
  logic        hreadyout_0, hresp_0, hreadyout_3, hresp_3;
  logic [31:0] hrdata_0, hrdata_3;
  logic [15:0] err_count_0, err_count_3;
  logic        cur_ready, cur_resp;
  logic [31:0] cur_rdata;

  int          total = 0;
  int          bad = 0;
  logic [31:0] rd;
  int          waits;
  logic        resp;

  always #5 clock = ~clock;

  assign htrans_0  = sel ? HTRANS_IDLE : htrans;
  assign htrans_3  = sel ? htrans : HTRANS_IDLE;
  assign cur_ready = sel ? hreadyout_3 : hreadyout_0;
  assign cur_resp  = sel ? hresp_3 : hresp_0;
  assign cur_rdata = sel ? hrdata_3 : hrdata_0;

  ahb_sram_responder #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .hready(hreadyout_0), .htrans(htrans_0),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hreadyout_0), .hresp(hresp_0), .hrdata(hrdata_0), .err_count(err_count_0)
  );

  ahb_sram_responder #(.WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .hready(hreadyout_3), .htrans(htrans_3),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hreadyout_3), .hresp(hresp_3), .hrdata(hrdata_3), .err_count(err_count_3)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated transfer: address phase, then data phase until ready.
  task automatic apply_stimulus(input logic wr, input logic [2:0] sz, input logic [29:0] a,
                                input logic [31:0] wd, output logic [31:0] rdv,
                                output int nwait, output logic rsp);
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    step();
    htrans = HTRANS_IDLE;
    hwdata = wd;
    nwait  = 0;
    rsp    = 1'b0;
    while (!cur_ready && nwait < 20) begin
      rsp = rsp | cur_resp;
      nwait++;
      step();
    end
    if (!cur_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL xfer_timeout observed=not_ready expected=ready_within_20");
    end
    rsp = rsp | cur_resp;
    rdv = cur_rdata;
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel    = 1'b0;
    htrans = HTRANS_IDLE;
    hsize  = HSIZE_WORD;
    hwrite = 1'b0;
    haddr  = '0;
    hwdata = '0;
    reset  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_ready0", 32'(hreadyout_0), 32'd1);
    check_output("rst_resp0", 32'(hresp_0), 32'd0);
    check_output("rst_rdata0", hrdata_0, 32'd0);
    check_output("rst_errcnt0", 32'(err_count_0), 32'd0);
    check_output("rst_ready3", 32'(hreadyout_3), 32'd1);
    reset = 1'b1;
    step();

    // Zero-wait write followed immediately by a read of the same word.
    $display("[TB] back-to-back write/read, zero wait states");
    sel    = 1'b0;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    haddr  = 30'h2000_0010;
    step();
    hwdata = 32'hDEADBEEF;
    hwrite = 1'b0;
    check_output("b2b_wr_ready", 32'(hreadyout_0), 32'd1);
    step();
    htrans = HTRANS_IDLE;
    check_output("b2b_rd_ready", 32'(hreadyout_0), 32'd1);
    check_output("b2b_rd_data", hrdata_0, 32'hDEADBEEF);
    step();

    // Three wait states on the second instance.
    $display("[TB] three wait states");
    sel = 1'b1;
    apply_stimulus(1'b1, HSIZE_WORD, 30'h2000_0020, 32'h1234_5678, rd, waits, resp);
    check_output("w3_wr_waits", 32'(waits), 32'd3);
    apply_stimulus(1'b0, HSIZE_WORD, 30'h2000_0020, 32'h0, rd, waits, resp);
    check_output("w3_rd_waits", 32'(waits), 32'd3);
    check_output("w3_rd_data", rd, 32'h1234_5678);
    check_output("w3_rd_resp", 32'(resp), 32'd0);

    // Byte and halfword lane merging.
    $display("[TB] byte lanes");
    sel = 1'b0;
    apply_stimulus(1'b1, HSIZE_WORD, 30'h2000_0000, 32'h1122_3344, rd, waits, resp);
    apply_stimulus(1'b1, HSIZE_BYTE, 30'h2000_0003, 32'hAA00_0000, rd, waits, resp);
    check_output("byte_wr_resp", 32'(resp), 32'd0);
    apply_stimulus(1'b0, HSIZE_WORD, 30'h2000_0000, 32'h0, rd, waits, resp);
    check_output("byte_rd_data", rd, 32'hAA22_3344);
    apply_stimulus(1'b1, HSIZE_HALF, 30'h2000_0000, 32'h0000_BEEF, rd, waits, resp);
    apply_stimulus(1'b0, HSIZE_WORD, 30'h2000_0000, 32'h0, rd, waits, resp);
    check_output("half_rd_data", rd, 32'hAA22_BEEF);

    // Out-of-window read, with a new transfer picked up in ERR2.
    $display("[TB] error response and ERR2 pipelining");
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    haddr  = 30'h2000_2000;
    step();
    htrans = HTRANS_IDLE;
    check_output("err1_ready", 32'(hreadyout_0), 32'd0);
    check_output("err1_resp", 32'(hresp_0), 32'd1);
    check_output("err1_count", 32'(err_count_0), 32'd1);
    step();
    check_output("err2_ready", 32'(hreadyout_0), 32'd1);
    check_output("err2_resp", 32'(hresp_0), 32'd1);
    htrans = HTRANS_NONSEQ;
    haddr  = 30'h2000_0010;
    step();
    htrans = HTRANS_IDLE;
    check_output("post_err_ready", 32'(hreadyout_0), 32'd1);
    check_output("post_err_resp", 32'(hresp_0), 32'd0);
    check_output("post_err_data", hrdata_0, 32'hDEADBEEF);
    step();

    // Misaligned halfword and oversize transfer must not touch memory.
    $display("[TB] illegal size/alignment");
    apply_stimulus(1'b1, HSIZE_HALF, 30'h2000_0001, 32'hFFFF_FFFF, rd, waits, resp);
    check_output("mis_half_waits", 32'(waits), 32'd1);
    check_output("mis_half_resp", 32'(resp), 32'd1);
    apply_stimulus(1'b1, 3'b011, 30'h2000_0000, 32'hFFFF_FFFF, rd, waits, resp);
    check_output("dword_waits", 32'(waits), 32'd1);
    check_output("dword_resp", 32'(resp), 32'd1);
    apply_stimulus(1'b0, HSIZE_WORD, 30'h2000_0000, 32'h0, rd, waits, resp);
    check_output("illegal_nochange", rd, 32'hAA22_BEEF);
    apply_stimulus(1'b0, HSIZE_WORD, 30'h1FFF_FFFC, 32'h0, rd, waits, resp);
    check_output("below_base_resp", 32'(resp), 32'd1);
    check_output("err_count_4", 32'(err_count_0), 32'd4);

    // Last word of the window is still legal.
    apply_stimulus(1'b1, HSIZE_WORD, 30'h2000_1FFC, 32'h5A5A_0001, rd, waits, resp);
    apply_stimulus(1'b0, HSIZE_WORD, 30'h2000_1FFC, 32'h0, rd, waits, resp);
    check_output("top_word_data", rd, 32'h5A5A_0001);
    check_output("top_word_resp", 32'(resp), 32'd0);

    // Reset during the wait states of a write drops the write.
    $display("[TB] reset during wait");
    sel    = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    haddr  = 30'h2000_0020;
    step();
    htrans = HTRANS_IDLE;
    hwdata = 32'hCAFE_F00D;
    check_output("rstw_wait_low", 32'(hreadyout_3), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_output("rstw_ready", 32'(hreadyout_3), 32'd1);
    check_output("rstw_resp", 32'(hresp_3), 32'd0);
    check_output("rstw_rdata", hrdata_3, 32'd0);
    check_output("rstw_errcnt0", 32'(err_count_0), 32'd0);
    #3;
    reset = 1'b1;
    step();
    apply_stimulus(1'b0, HSIZE_WORD, 30'h2000_0020, 32'h0, rd, waits, resp);
    check_output("rstw_old_data", rd, 32'h1234_5678);
    check_output("rstw_rd_waits", 32'(waits), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_sram_responder.md
AHB_SRAM_RESPONDER -- requirements
Module: ahb_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, HADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed at 32 (word = 4 bytes).
REQ-003 SHALL have parameter BASE_ADDR, default 0x2000_0000, first byte of the mapped window.
REQ-004 SHALL have parameter MEM_BYTES, default 8192, window size, power of two.
REQ-005 SHALL have parameter WAIT_CYCLES, default 1, range 0..7, fixed data-phase wait states.
REQ-006 SHALL have port clock, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1, reset that is asynchronous and active-low.
REQ-008 SHALL have port hready, input, 1, bus HREADY.
REQ-009 SHALL have port htrans, input, 2, transfer type.
REQ-010 SHALL have port hsize, input, 3, transfer size.
REQ-011 SHALL have port hwrite, input, 1, write when high.
REQ-012 SHALL have port haddr, input, ADDR_WIDTH, byte address.
REQ-013 SHALL have port hwdata, input, 32, write data, valid in the data phase.
REQ-014 SHALL have port hreadyout, output, 1, slave ready.
REQ-015 SHALL have port hresp, output, 1, 1 = ERROR.
REQ-016 SHALL have port hrdata, output, 32, read data.
REQ-017 SHALL have port err_count, output, 16, saturating count of ERROR responses.

Function
REQ-018 SHALL accept an address phase only when hready=1 and htrans[1]=1 (NONSEQ/SEQ); IDLE/BUSY give a zero-wait OKAY response.
REQ-019 SHALL run an FSM with states IDLE, WAIT, ERR1 and ERR2.
REQ-020 SHALL go from an accepted legal transfer to WAIT when the wait load is nonzero, else complete in the next cycle with hreadyout=1 and hresp=0.
REQ-021 SHALL in WAIT drive hreadyout=0, decrement a 3-bit counter, and set hreadyout=1 in the cycle after the counter reaches 0.
REQ-022 SHALL treat a transfer as illegal if the address is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES), hsize>2, or haddr is not aligned to hsize.
REQ-023 SHALL send an illegal transfer to ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE, with no memory access and no wait states.
REQ-024 SHALL in ERR2 and in the final OKAY cycle sample a new address phase per REQ-018, so back-to-back transfers add no bubble.
REQ-025 SHALL ignore a transfer in ERR1 that the master cancels (htrans=IDLE).
REQ-026 SHALL commit a write in its last data-phase cycle (hreadyout=1) using hwdata and the byte lanes decoded from the latched hsize and haddr[1:0].
REQ-027 SHALL read memory combinationally from the latched address and drive hrdata only in the last read data-phase cycle, and 0 otherwise.
REQ-028 SHALL make a read issued directly after a write to the same word return the new data, with no hazard.
REQ-029 SHALL increment err_count on entry to ERR1 and hold it at 0xFFFF once saturated.

Reset
REQ-030 SHALL on reset=0 force state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter 0, err_count 0, and LFSR 3'b001.
REQ-031 SHALL on reset mid-transfer drop the transfer with no write committed; memory contents are not reset.

Configuration
REQ-032 SHALL with AHB_SRAM_RESPONDER_LFSR_WAIT_EN defined load the wait count of each legal transfer from a 3-bit maximal LFSR (x^3+x^2+1) that advances once per accepted transfer.
REQ-033 SHALL without AHB_SRAM_RESPONDER_LFSR_WAIT_EN load WAIT_CYCLES and contain no LFSR logic.

Structure
REQ-034 SHALL place the state enum, htrans encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), hsize encodings and the OKAY/ERROR constants in package ahb_sram_responder_pkg.
REQ-035 SHALL place the byte-enabled storage array in one sub-module, ahb_sram_responder_mem (word-addressed, 4 byte enables, combinational read).

Verification
REQ-036 SHALL cover WAIT_CYCLES=0: write 0xDEADBEEF to 0x2000_0010, then read the same address back-to-back -> read data 0xDEADBEEF, hreadyout never low.
REQ-037 SHALL cover WAIT_CYCLES=3: a word read -> exactly 3 cycles with hreadyout=0, then hreadyout=1 with the data.
REQ-038 SHALL cover a byte write of 0xAA at 0x2000_0003 over word 0x11223344 -> read gives 0xAA223344.
REQ-039 SHALL cover a read at 0x2000_2000 -> ERR1 then ERR2, err_count=1, and a following NONSEQ sampled in ERR2 completes OKAY.
REQ-040 SHALL cover a halfword at 0x2000_0001 and hsize=3 -> each gets a two-cycle ERROR and no memory change.
REQ-041 SHALL cover reset=0 asserted during WAIT of a write -> outputs return to reset values and a read-back returns the old data.
